// File: rtl/fabric_load_port.sv
`default_nettype none
// ============================================================================
// Module   : fabric_load_port
// Purpose  : Credit-flow-controlled read port between a fabric load PE and a
//            fixed-latency SRAM; absorbs out-of-range addresses as zero reads.
// Revision : 1.0
// ============================================================================
module fabric_load_port #(
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_WIDTH   = 0,
    parameter int ADDR_WIDTH  = 10,
    parameter int MEM_DEPTH   = 1024,
    parameter int MEM_LATENCY = 2,
    parameter int RESP_DEPTH  = 4,
    localparam int REQ_PW     = DATA_WIDTH + TAG_WIDTH,
    localparam int SAFE_TW    = (TAG_WIDTH > 0) ? TAG_WIDTH : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [REQ_PW-1:0]     req_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [SAFE_TW-1:0]    resp_tag,
    output logic                  err_oob
);

    localparam int C_CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int C_PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [C_CNT_W-1:0]  C_CNT_MAX  = C_CNT_W'(RESP_DEPTH);
    localparam logic [C_PTR_W-1:0]  C_PTR_LAST = C_PTR_W'(RESP_DEPTH - 1);
    localparam logic [DATA_WIDTH:0] C_MEM_LIM  = (DATA_WIDTH + 1)'(MEM_DEPTH);

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_in_range;
    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_value;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [SAFE_TW-1:0]    w_tag;

    logic [C_CNT_W-1:0]    r_cnt;
    logic [MEM_LATENCY-1:0] r_pv;
    logic [MEM_LATENCY-1:0] r_po;
    logic [SAFE_TW-1:0]    r_pt [MEM_LATENCY];
    logic [DATA_WIDTH-1:0] r_fd [RESP_DEPTH];
    logic [SAFE_TW-1:0]    r_ft [RESP_DEPTH];
    logic [C_PTR_W-1:0]    r_wp;
    logic [C_PTR_W-1:0]    r_rp;
    logic [C_CNT_W-1:0]    r_fcnt;
    logic                  r_err;

    generate
        if (TAG_WIDTH > 0) begin : g_tag
            assign w_tag = req_data[REQ_PW-1:DATA_WIDTH];
        end else begin : g_no_tag
            assign w_tag = '0;
        end
    endgenerate

    // Credits are withheld while reset is asserted so nothing is accepted.
    assign req_ready   = rst_n && (r_cnt < C_CNT_MAX);
    assign w_value     = req_data[DATA_WIDTH-1:0];
    assign w_in_range  = ({1'b0, w_value} < C_MEM_LIM);
    assign w_accept    = req_valid && req_ready;
    assign w_pop       = resp_valid && resp_ready;
    assign mem_rd_en   = w_accept && w_in_range;
    assign mem_rd_addr = w_value[ADDR_WIDTH-1:0];

    assign w_wr        = r_pv[MEM_LATENCY-1];
    assign w_wr_data   = r_po[MEM_LATENCY-1] ? '0 : mem_rd_data;

    assign resp_valid  = (r_fcnt != '0);
    assign resp_data   = r_fd[r_rp];
    assign resp_tag    = r_ft[r_rp];
    assign err_oob     = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept && !w_pop) begin
                r_cnt <= r_cnt + C_CNT_W'(1);
            end else if (!w_accept && w_pop) begin
                r_cnt <= r_cnt - C_CNT_W'(1);
            end
            if (w_accept && !w_in_range) begin
                r_err <= 1'b1;
            end
        end
    end

    // Tracking pipeline mirrors the SRAM latency; its exit marks valid read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            r_po <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_pt[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_po[0] <= w_accept && !w_in_range;
            r_pt[0] <= w_tag;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_po[i] <= r_po[i-1];
                r_pt[i] <= r_pt[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                r_fd[i] <= '0;
                r_ft[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_fd[r_wp] <= w_wr_data;
                r_ft[r_wp] <= r_pt[MEM_LATENCY-1];
                r_wp       <= (r_wp == C_PTR_LAST) ? '0 : r_wp + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rp <= (r_rp == C_PTR_LAST) ? '0 : r_rp + C_PTR_W'(1);
            end
            if (w_wr && !w_pop) begin
                r_fcnt <= r_fcnt + C_CNT_W'(1);
            end else if (!w_wr && w_pop) begin
                r_fcnt <= r_fcnt - C_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fabric_load_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_fabric_load_port
// Purpose  : Randomized self-checking bench against a queue-based response model.
// Revision : 1.0
// ============================================================================
module tb_fabric_load_port;

    localparam int DW    = 32;
    localparam int TW    = 2;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int RD    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW+TW-1:0] req_data = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_data;
    logic [TW-1:0] resp_tag;
    logic          err_oob;

    always #5 clk = ~clk;

    fabric_load_port #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (DEPTH),
        .MEM_LATENCY(LAT),
        .RESP_DEPTH (RD)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .err_oob    (err_oob)
    );

    // SRAM: two-cycle latency, random garbage on cycles without a strobe.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] r_d1 = '0;
    logic [DW-1:0] r_d2 = '0;
    assign mem_rd_data = r_d2;
    always @(posedge clk) begin
        r_d1 <= mem_rd_en ? mem[mem_rd_addr] : $urandom;
        r_d2 <= r_d1;
    end

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        int            avail;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    bit   exp_err  = 1'b0;
    int   n_checks = 0;
    int   n_errs   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                        input bit rr);
        bit   exp_rdy;
        bit   exp_vld;
        bit   acc;
        bit   oob;
        exp_t e;
        @(negedge clk);
        req_valid  = v;
        req_data   = {tag, addr};
        resp_ready = rr;
        #1;
        exp_rdy = (q.size() < RD);
        exp_vld = (q.size() > 0) && (q[0].avail <= cyc);
        acc     = v && exp_rdy;
        oob     = (addr >= DEPTH);
        chk("req_ready", req_ready, exp_rdy);
        chk("resp_valid", resp_valid, exp_vld);
        if (exp_vld) begin
            chk("resp_data", resp_data, q[0].data);
            chk("resp_tag", resp_tag, q[0].tag);
        end
        chk("mem_rd_en", mem_rd_en, acc && !oob);
        if (acc && !oob) begin
            chk("mem_rd_addr", mem_rd_addr, addr[AW-1:0]);
        end
        chk("err_oob", err_oob, exp_err);
        if (exp_vld && rr) begin
            void'(q.pop_front());
        end
        if (acc) begin
            e.data  = oob ? '0 : mem[addr[AW-1:0]];
            e.tag   = tag;
            e.avail = cyc + LAT + 1;
            q.push_back(e);
            if (oob) begin
                exp_err = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        #1;
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_err_oob", err_oob, 1'b0);
        chk("rst_mem_rd_en", mem_rd_en, 1'b0);
        q.delete();
        exp_err = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_hold_resp_valid", resp_valid, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready", req_ready, 1'b1);
    endtask

    bit            v;
    int            sel;
    logic [DW-1:0] a;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
        end
        mem[5] = 32'hDEAD_BEEF;

        do_reset();

        // single read
        step(1'b1, 32'd5, 2'd0, 1'b1);
        idle(5);

        // streaming 0..7
        for (int i = 0; i < 8; i++) begin
            step(1'b1, DW'(i), 2'd0, 1'b1);
        end
        idle(6);

        // backpressure: 6 offered, 4 fit
        for (int i = 0; i < 6; i++) begin
            step(1'b1, DW'(100 + i), TW'(i), 1'b0);
        end
        repeat (3) step(1'b0, '0, '0, 1'b0);
        idle(8);

        // tagged
        step(1'b1, 32'd10, 2'd3, 1'b1);
        step(1'b1, 32'd11, 2'd1, 1'b1);
        step(1'b1, 32'd12, 2'd2, 1'b1);
        idle(5);

        // out of range, including the upper-bit alias of address 5
        step(1'b1, 32'd20, 2'd0, 1'b1);
        step(1'b1, 32'd1024, 2'd3, 1'b1);
        step(1'b1, 32'd21, 2'd0, 1'b1);
        step(1'b1, 32'd1023, 2'd1, 1'b1);
        step(1'b1, 32'h0001_0005, 2'd2, 1'b1);
        idle(6);

        // reset with three reads outstanding, then a fresh read
        step(1'b1, 32'd30, 2'd0, 1'b0);
        step(1'b1, 32'd31, 2'd1, 1'b0);
        step(1'b1, 32'd32, 2'd2, 1'b0);
        do_reset();
        idle(4);
        step(1'b1, 32'd7, 2'd3, 1'b1);
        idle(6);

        // randomized traffic
        repeat (400) begin
            v   = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 9);
            if (sel < 8) begin
                a = DW'($urandom_range(0, DEPTH - 1));
            end else if (sel == 8) begin
                a = DW'($urandom_range(DEPTH, DEPTH + 80));
            end else begin
                a = $urandom;
            end
            step(v, a, TW'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0));
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
